// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and widths for the register-file write arbiter.
// Used by the interface, the round-robin arbiter and the top.
package regfile_arb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] address;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback request bus plus register_file write port.
// The arbiter is the slave; the writeback sources and register_file side form the master.
interface regfile_write_arbiter_if #(
    parameter int NUM_REQ = 2
) ();
    logic [NUM_REQ-1:0]                                  req_valid;
    logic [NUM_REQ-1:0]                                  req_ready;
    logic [NUM_REQ-1:0][regfile_arb_pkg::REG_ADDR_W-1:0] req_address;
    logic [NUM_REQ-1:0][regfile_arb_pkg::XLEN-1:0]       req_data;
    logic [regfile_arb_pkg::REG_ADDR_W-1:0]              write_address;
    logic [regfile_arb_pkg::XLEN-1:0]                    write_data;
    logic                                                write_enable;

    modport master (
        output req_valid,
        output req_address,
        output req_data,
        input  req_ready,
        input  write_address,
        input  write_data,
        input  write_enable
    );

    modport slave (
        input  req_valid,
        input  req_address,
        input  req_data,
        output req_ready,
        output write_address,
        output write_data,
        output write_enable
    );
endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Generic NUM_REQ-wide round-robin arbiter with its own pointer register.
// Every grant is taken as a transfer, so the pointer moves past the winner each grant.
module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [PTR_W-1:0]   grant_idx_o,
    output logic               grant_valid_o
);
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W:0]   cand;
    logic             found;

    // Scan from ptr_q upward with wrap; first valid requester wins.
    always_comb begin
        grant_o       = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        found         = 1'b0;
        cand          = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(NUM_REQ)) begin
                cand = cand - (PTR_W+1)'(NUM_REQ);
            end
            if (!found && req_i[cand[PTR_W-1:0]]) begin
                found       = 1'b1;
                grant_idx_o = cand[PTR_W-1:0];
            end
        end
        if (found && !rst) begin
            grant_valid_o        = 1'b1;
            grant_o[grant_idx_o] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_valid_o) begin
            if (grant_idx_o == PTR_W'(NUM_REQ-1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx_o + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single register-file write port, one-cycle registered output.
// REGFILE_WRITE_ARBITER_FORWARD_EN adds write-to-read bypass on two read ports.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_write_arbiter_if.slave wb
`ifdef REGFILE_WRITE_ARBITER_FORWARD_EN
    ,
    input  logic [REG_ADDR_W-1:0] read_address1_i,
    input  logic [REG_ADDR_W-1:0] read_address2_i,
    input  logic [XLEN-1:0]       rf_read_data1_i,
    input  logic [XLEN-1:0]       rf_read_data2_i,
    output logic [XLEN-1:0]       read_data1_o,
    output logic [XLEN-1:0]       read_data2_o
`endif
);
    logic [NUM_REQ-1:0]    grant;
    logic [PTR_W-1:0]      grant_idx;
    logic                  xfer;
    wb_req_t               sel;
    logic                  commit;

    logic                  we_q;
    logic                  we_d;
    logic [REG_ADDR_W-1:0] addr_q;
    logic [REG_ADDR_W-1:0] addr_d;
    logic [XLEN-1:0]       data_q;
    logic [XLEN-1:0]       data_d;

    logic                  we_out;
    logic [REG_ADDR_W-1:0] addr_out;
    logic [XLEN-1:0]       data_out;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk           (clk),
        .rst           (rst),
        .req_i         (wb.req_valid),
        .grant_o       (grant),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (xfer)
    );

    assign wb.req_ready = grant;

    always_comb begin
        sel.address = wb.req_address[grant_idx];
        sel.data    = wb.req_data[grant_idx];
    end

    // x0 requests are accepted and consumed but never reach the register file.
    assign commit = xfer && (sel.address != '0);

    always_comb begin
        we_d   = commit;
        addr_d = addr_q;
        data_d = data_q;
        if (commit) begin
            addr_d = sel.address;
            data_d = sel.data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    // Masking by rst drops a registered write whose commit cycle is hit by reset.
    assign we_out   = we_q & ~rst;
    assign addr_out = rst ? '0 : addr_q;
    assign data_out = rst ? '0 : data_q;

    assign wb.write_enable  = we_out;
    assign wb.write_address = addr_out;
    assign wb.write_data    = data_out;

`ifdef REGFILE_WRITE_ARBITER_FORWARD_EN
    always_comb begin
        read_data1_o = rf_read_data1_i;
        read_data2_o = rf_read_data2_i;
        if (we_out && (addr_out == read_address1_i) && (read_address1_i != '0)) begin
            read_data1_o = data_out;
        end
        if (we_out && (addr_out == read_address2_i) && (read_address2_i != '0)) begin
            read_data2_o = data_out;
        end
    end
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter with NUM_REQ=2, a reference register file and a write scoreboard.
module tb_regfile_write_arbiter;
    localparam int N = 2;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    regfile_write_arbiter_if #(.NUM_REQ(N)) bus ();

    logic [31:0] rf_dut [32];
    logic [31:0] ref_rf [32];

`ifdef REGFILE_WRITE_ARBITER_FORWARD_EN
    logic [4:0]  ra1 = '0;
    logic [4:0]  ra2 = '0;
    logic [31:0] rf_rd1;
    logic [31:0] rf_rd2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    assign rf_rd1 = rf_dut[ra1];
    assign rf_rd2 = rf_dut[ra2];
`endif

    regfile_write_arbiter #(.NUM_REQ(N)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus)
`ifdef REGFILE_WRITE_ARBITER_FORWARD_EN
        ,
        .read_address1_i (ra1),
        .read_address2_i (ra2),
        .rf_read_data1_i (rf_rd1),
        .rf_read_data2_i (rf_rd2),
        .read_data1_o    (rd1),
        .read_data2_o    (rd2)
`endif
    );

    always #5 clk = ~clk;

    // register_file: writes whatever it is told, so a stray x0 write is visible
    always @(posedge clk) begin
        if (bus.write_enable) rf_dut[bus.write_address] <= bus.write_data;
    end

    typedef struct {
        logic        nz;
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;

    exp_t        sb_q [$];
    exp_t        e;
    int          m_ptr   = 0;
    logic        m_we    = 1'b0;
    logic [4:0]  m_addr  = '0;
    logic [31:0] m_data  = '0;
    logic        prev_rst = 1'b1;
    logic        ew;
    logic [4:0]  ea;
    logic [31:0] ed;
    logic [N-1:0] er;
    int          g;
    int          idx;

    // Scoreboard: push accepted requests, pop them one cycle later against the write port.
    always @(negedge clk) begin
        if (prev_rst) begin
            m_we = 1'b0; m_addr = '0; m_data = '0;
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (!prev_rst) begin
                m_we = e.nz;
                if (e.nz) begin m_addr = e.a; m_data = e.d; end
            end
        end else begin
            m_we = 1'b0;
        end
        ew = rst ? 1'b0 : m_we;
        ea = rst ? 5'd0 : m_addr;
        ed = rst ? 32'd0 : m_data;
        checks++;
        if ({bus.write_enable, bus.write_address, bus.write_data} !== {ew, ea, ed}) begin
            errors++;
            $display("FAIL sb_write t=%0t we/addr/data actual %b/%0d/%h required %b/%0d/%h",
                     $time, bus.write_enable, bus.write_address, bus.write_data, ew, ea, ed);
        end
        if (!rst && m_we) ref_rf[m_addr] = m_data;

        er = '0;
        g  = -1;
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (g < 0 && bus.req_valid[idx]) g = idx;
            end
        end
        if (g >= 0) er[g] = 1'b1;
        checks++;
        if (bus.req_ready !== er) begin
            errors++;
            $display("FAIL sb_ready t=%0t actual %b required %b", $time, bus.req_ready, er);
        end
        if (g >= 0) begin
            sb_q.push_back('{nz: (bus.req_address[g] != 5'd0), a: bus.req_address[g], d: bus.req_data[g]});
            m_ptr = (g == N-1) ? 0 : g + 1;
        end
        if (rst) m_ptr = 0;
        prev_rst = rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 2'b11;
        bus.req_address[0] = 5'd9;  bus.req_data[0] = 32'h0000_0009;
        bus.req_address[1] = 5'd10; bus.req_data[1] = 32'h0000_000A;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (bus.req_ready !== 2'b00 || bus.write_enable !== 1'b0 || bus.write_address !== 5'd0) begin
                errors++;
                $display("FAIL reset cyc%0d ready/we/addr actual %b/%b/%0d required 00/0/0",
                         c, bus.req_ready, bus.write_enable, bus.write_address);
            end
            tick();
        end
        rst = 1'b0;
        bus.req_valid = 2'b00;
        tick();
    endtask

    task automatic test_single();
        bus.req_valid = 2'b01;
        bus.req_address[0] = 5'd1; bus.req_data[0] = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 2'b01) begin
            errors++; $display("FAIL single_ready actual %b required 01", bus.req_ready);
        end
        tick();
        bus.req_valid = 2'b00;
        @(negedge clk);
        checks++;
        if (bus.write_enable !== 1'b1 || bus.write_address !== 5'd1 || bus.write_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL single_write actual %b/%0d/%h required 1/1/deadbeef",
                     bus.write_enable, bus.write_address, bus.write_data);
        end
        tick();
        checks++;
        if (rf_dut[1] !== 32'hDEAD_BEEF || rf_dut[1] !== ref_rf[1]) begin
            errors++; $display("FAIL single_rf x1 actual %h required deadbeef", rf_dut[1]);
        end
    endtask

    task automatic test_contention();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req_valid = 2'b11;
        bus.req_address[0] = 5'd2; bus.req_data[0] = 32'hCAFE_BABE;
        bus.req_address[1] = 5'd3; bus.req_data[1] = 32'h1234_5678;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 2'b01) begin
            errors++; $display("FAIL cont_grant0 actual %b required 01", bus.req_ready);
        end
        tick();
        bus.req_valid = 2'b10;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 2'b10) begin
            errors++; $display("FAIL cont_grant1 actual %b required 10", bus.req_ready);
        end
        tick();
        bus.req_valid = 2'b00;
        tick();
        checks++;
        if (rf_dut[2] !== 32'hCAFE_BABE || rf_dut[3] !== 32'h1234_5678 ||
            rf_dut[2] !== ref_rf[2] || rf_dut[3] !== ref_rf[3]) begin
            errors++;
            $display("FAIL cont_rf x2/x3 actual %h/%h required cafebabe/12345678", rf_dut[2], rf_dut[3]);
        end
    endtask

    task automatic test_fairness();
        logic [N-1:0] want;
        bus.req_address[0] = 5'd6; bus.req_data[0] = 32'hA000_0000;
        bus.req_address[1] = 5'd7; bus.req_data[1] = 32'hA000_0001;
        bus.req_valid = 2'b11;
        for (int i = 0; i < 6; i++) begin
            want = (i % 2 == 0) ? 2'b01 : 2'b10;
            @(negedge clk);
            checks++;
            if (bus.req_ready !== want) begin
                errors++; $display("FAIL fair_grant%0d actual %b required %b", i, bus.req_ready, want);
            end
            tick();
            bus.req_data[i % 2] = 32'hA000_0000 + 32'(i + 2);
        end
        bus.req_valid = 2'b00;
        tick();
        tick();
        checks++;
        if (rf_dut[6] !== 32'hA000_0004 || rf_dut[7] !== 32'hA000_0005 ||
            rf_dut[6] !== ref_rf[6] || rf_dut[7] !== ref_rf[7]) begin
            errors++;
            $display("FAIL fair_rf x6/x7 actual %h/%h required a0000004/a0000005", rf_dut[6], rf_dut[7]);
        end
    endtask

    task automatic test_x0();
        bus.req_valid = 2'b10;
        bus.req_address[1] = 5'd0; bus.req_data[1] = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 2'b10) begin
            errors++; $display("FAIL x0_ready actual %b required 10", bus.req_ready);
        end
        tick();
        bus.req_valid = 2'b00;
        @(negedge clk);
        checks++;
        if (bus.write_enable !== 1'b0 || bus.write_address !== 5'd7 || bus.write_data !== 32'hA000_0005) begin
            errors++;
            $display("FAIL x0_hold actual %b/%0d/%h required 0/7/a0000005",
                     bus.write_enable, bus.write_address, bus.write_data);
        end
        tick();
        checks++;
        if (rf_dut[0] !== 32'd0) begin
            errors++; $display("FAIL x0_rf actual %h required 0", rf_dut[0]);
        end
    endtask

    task automatic test_reset_midop();
        bus.req_valid = 2'b01;
        bus.req_address[0] = 5'd4; bus.req_data[0] = 32'h1111_1111;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 2'b01) begin
            errors++; $display("FAIL midrst_ready actual %b required 01", bus.req_ready);
        end
        tick();
        bus.req_valid = 2'b00;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.write_enable !== 1'b0) begin
            errors++; $display("FAIL midrst_we actual %b required 0", bus.write_enable);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (rf_dut[4] !== 32'd0 || rf_dut[4] !== ref_rf[4]) begin
            errors++; $display("FAIL midrst_rf x4 actual %h required 0", rf_dut[4]);
        end
    endtask

`ifdef REGFILE_WRITE_ARBITER_FORWARD_EN
    task automatic test_forward();
        ra1 = 5'd5;
        ra2 = 5'd0;
        bus.req_valid = 2'b01;
        bus.req_address[0] = 5'd5; bus.req_data[0] = 32'hA5A5_A5A5;
        tick();
        bus.req_valid = 2'b00;
        @(negedge clk);
        checks++;
        if (rd1 !== 32'hA5A5_A5A5 || rd2 !== 32'd0) begin
            errors++; $display("FAIL fwd_bypass rd1/rd2 actual %h/%h required a5a5a5a5/0", rd1, rd2);
        end
        tick();
        @(negedge clk);
        checks++;
        if (rd1 !== 32'hA5A5_A5A5 || bus.write_enable !== 1'b0) begin
            errors++; $display("FAIL fwd_rf rd1 actual %h required a5a5a5a5", rd1);
        end
        tick();
    endtask
`endif

    initial begin
        for (int r = 0; r < 32; r++) begin
            rf_dut[r] = '0;
            ref_rf[r] = '0;
        end
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_address = '0;
        bus.req_data = '0;
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_x0();
        test_reset_midop();
`ifdef REGFILE_WRITE_ARBITER_FORWARD_EN
        test_forward();
`endif
        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
